diag_bus_receiver: RTL and testbench
====================================

Name: diag_bus_receiver

Overview:
- PE-side receive end of the NOC diagonal ifmap bus.
- Snoops the broadcast diagonal bus packet and captures only the payloads addressed to its diagonal. Captured data goes into a local FIFO, which the PE compute logic drains.
- Drives back the per-diagonal pe_full flow control and the row-completion count that the NOC consumes for scheduling and for freeing its ifmap buffer.

Parameters:
- DATA_W, 64, payload width per packet.
- DEPTH, 8, FIFO entries; power of two, at least 4.
- DIAG_W, 4, width of the diagonal destination field (12 diagonals in a 6x7 array).
- MY_DIAG, 0, diagonal index this instance accepts.
- AF_MARGIN, 2, free entries reserved to absorb NOC bus latency after pe_full is asserted.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; clears the FIFO and counters and enters RECV.
- rows_expected  in  5  number of last-flagged rows in this convolution; sampled on start.
- pkt_valid  in  1  bus packet valid.
- pkt_dest  in  DIAG_W  destination diagonal.
- pkt_last  in  1  final word of an ifmap row.
- pkt_data  in  DATA_W  payload.
- rd_valid  out  1  FIFO not empty; first-word-fall-through.
- rd_data  out  DATA_W  head entry.
- rd_last  out  1  last flag of the head entry.
- rd_ready  in  1  PE pops the head when rd_valid and rd_ready.
- pe_full  out  1  registered almost-full flag to the NOC.
- row_done  out  1  one-cycle pulse when a last-flagged entry is popped.
- complete_count  out  5  rows popped since start.
- calc_complete  out  1  level; complete_count has reached rows_expected.
- overflow  out  1  sticky error; a matching packet arrived while the FIFO was full.

Behaviour:
- Reset values:
  - All outputs are 0; rd_data is 0.
  - Pointers and occupancy are 0.
  - FSM is in IDLE.
- FSM:
  - IDLE: no packet is accepted. start goes to RECV.
  - RECV: start again re-clears and stays in RECV. When complete_count == rows_expected, go to DONE.
  - DONE: calc_complete = 1. Packets are still accepted and popped, but complete_count saturates. start goes to RECV.
- start, in any state, synchronously clears:
  - FIFO pointers and occupancy;
  - complete_count;
  - overflow;
  - calc_complete.
  - It also latches rows_expected. A push or pop in the same cycle as start is discarded.
- rows_expected = 0 on start goes straight to DONE on the next cycle.
- Match condition: pkt_valid && pkt_dest == MY_DIAG && state != IDLE.
- Push: match && occupancy < DEPTH. {pkt_last, pkt_data} is written at the tail; it is visible on rd_* the cycle after the push edge.
- match && occupancy == DEPTH: the packet is dropped and overflow is set. This holds even if a pop occurs in the same cycle; full is evaluated pre-pop.
- Pop: rd_valid && rd_ready. rd_ready while empty is ignored.
- Simultaneous push and pop with 0 < occupancy < DEPTH: occupancy is unchanged and both pointers advance.
- Pointers are log2(DEPTH) bits and wrap naturally. Occupancy is log2(DEPTH)+1 bits.
- pe_full is registered: it is 1 in the cycle after occupancy_next >= DEPTH - AF_MARGIN, and 0 otherwise.
- Row completion:
  - A pop with rd_last = 1 makes row_done = 1 next cycle and increments complete_count.
  - complete_count saturates at 31.
  - calc_complete rises the cycle after complete_count reaches rows_expected.
- Reset mid-operation: everything returns immediately to reset values and the contents are discarded.

Decomposition:
- Shared package (noc_pkg), extended:
  - DIAGONAL_BUS_PACKET struct {valid, dest[DIAG_W], last, data[DATA_W]};
  - RX_STATE enum {RX_IDLE, RX_RECV, RX_DONE};
  - constants DIAG_NUM = 12 and the default DATA_W.
- One sub-module: sync_fifo_fwft. It holds storage, pointers and occupancy, and has push/pop/full/empty/count ports. The FSM, match logic, pe_full, counters and overflow stay in the top level.

Test Plan:
- Reset, then start with rows_expected=2, MY_DIAG=3; send 4 packets with dest=3 (data 0xA0..0xA3, last on the 2nd and 4th); PE pops continuously -> rd_data order A0..A3, row_done pulses twice, complete_count=2, calc_complete=1 one cycle after the 2nd pulse.
- Packets with dest=5 and with pkt_valid=0 -> no push, rd_valid stays 0, overflow 0.
- rd_ready=0, push 6 packets with DEPTH=8, AF_MARGIN=2 -> pe_full is 0 after 5 pushes and 1 the cycle after the 6th push. Push 2 more -> occupancy 8; a 9th matching packet -> dropped, overflow=1. Pop 1 -> pe_full drops only once occupancy_next is 5.
- With the FIFO half full, push and pop every cycle for 20 cycles -> occupancy stays constant, data stays in order across pointer wrap, no overflow.
- Packets sent in IDLE before start -> ignored. start pulsed mid-RECV with 3 entries held -> rd_valid=0 next cycle, complete_count=0, overflow cleared.
- rst asserted asynchronously mid-transfer -> all outputs 0 without waiting for a clock edge; FSM in IDLE after release.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NOC definitions: diagonal bus packet layout, receiver FSM states and array constants.
package noc_pkg;

    localparam int DIAG_NUM       = 12;
    localparam int DATA_W_DEFAULT = 64;
    localparam int DIAG_W_DEFAULT = 4;

    // One beat of the broadcast diagonal ifmap bus.
    typedef struct packed {
        logic                      valid;
        logic [DIAG_W_DEFAULT-1:0] dest;
        logic                      last;
        logic [DATA_W_DEFAULT-1:0] data;
    } diagonal_bus_packet_t;

    // Receiver state, visible to checkers through diag_bus_receiver.state.
    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_RECV = 2'd1,
        RX_DONE = 2'd2
    } rx_state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO. The head entry is presented on
// rdata while not empty; rdata reads as zero when empty. clr empties the FIFO
// and overrides any push/pop in the same cycle. Push while full and pop while
// empty are ignored, and fullness is judged before any same-cycle pop.
module sync_fifo_fwft #(
    parameter  int WIDTH = 65,
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !clr;
    assign do_pop  = pop && !empty && !clr;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Storage write; contents are not reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally; occupancy tracks push/pop difference.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/diag_bus_receiver.sv
// PE-side receiver of the NOC diagonal ifmap bus. Captures packets addressed
// to MY_DIAG into a FWFT FIFO, reports almost-full back to the NOC and counts
// completed rows as the PE drains them.
//
// Handshake: the read side is valid/ready. rd_valid means rd_data/rd_last hold
// the head entry and stay stable until popped; the entry is consumed on a
// rising clock edge where rd_valid && rd_ready. rd_ready while empty does
// nothing. The bus side has no ready: the NOC must honour pe_full, and a
// matching packet arriving with the FIFO full is dropped and flagged.
module diag_bus_receiver
    import noc_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int DEPTH     = 8,
    parameter int DIAG_W    = DIAG_W_DEFAULT,
    parameter int MY_DIAG   = 0,
    parameter int AF_MARGIN = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4:0]        rows_expected,
    input  logic              pkt_valid,
    input  logic [DIAG_W-1:0] pkt_dest,
    input  logic              pkt_last,
    input  logic [DATA_W-1:0] pkt_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    input  logic              rd_ready,
    output logic              pe_full,
    output logic              row_done,
    output logic [4:0]        complete_count,
    output logic              calc_complete,
    output logic              overflow
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    rx_state_t        state;
    rx_state_t        state_next;
    logic [4:0]       rows_exp_q;
    logic             match;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [DATA_W:0]  fifo_rdata;
    logic [CNT_W-1:0] occ_next;

    assign match    = pkt_valid && (pkt_dest == DIAG_W'(MY_DIAG)) && (state != RX_IDLE);
    // A push or pop coinciding with start is discarded along with the old contents.
    assign push     = match && !fifo_full && !start;
    assign pop      = !fifo_empty && rd_ready && !start;

    assign rd_valid      = !fifo_empty;
    assign rd_data       = fifo_rdata[DATA_W-1:0];
    assign rd_last       = fifo_rdata[DATA_W];
    assign calc_complete = (state == RX_DONE);

    sync_fifo_fwft #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (start),
        .push  (push),
        .pop   (pop),
        .wdata ({pkt_last, pkt_data}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Occupancy after this cycle's push/pop, used for the registered almost-full.
    always_comb begin
        occ_next = fifo_count;
        if (push && !pop) occ_next = fifo_count + 1'b1;
        if (pop && !push) occ_next = fifo_count - 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RX_IDLE;
        else     state <= state_next;
    end

    // FSM next state: start always (re)enters RECV; RECV ends once all rows are popped.
    always_comb begin
        state_next = state;
        if (start) begin
            state_next = RX_RECV;
        end else begin
            case (state)
                RX_IDLE: state_next = RX_IDLE;
                RX_RECV: if (complete_count == rows_exp_q) state_next = RX_DONE;
                RX_DONE: state_next = RX_DONE;
                default: state_next = RX_IDLE;
            endcase
        end
    end

    // Flow control, row accounting and overflow flag; start clears them all.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rows_exp_q     <= '0;
            pe_full        <= 1'b0;
            row_done       <= 1'b0;
            complete_count <= '0;
            overflow       <= 1'b0;
        end else if (start) begin
            rows_exp_q     <= rows_expected;
            pe_full        <= 1'b0;
            row_done       <= 1'b0;
            complete_count <= '0;
            overflow       <= 1'b0;
        end else begin
            pe_full  <= (occ_next >= CNT_W'(DEPTH - AF_MARGIN));
            row_done <= pop && rd_last;
            if (pop && rd_last && (complete_count != 5'd31)) begin
                complete_count <= complete_count + 5'd1;
            end
            if (match && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_diag_bus_receiver.sv
// Directed bench for diag_bus_receiver (MY_DIAG=3, DEPTH=8, AF_MARGIN=2).
// The driver pushes expected {last,data} words into exp_q as it issues
// matching packets; a negedge monitor pops and compares on every handshake.
module tb_diag_bus_receiver;

    localparam int DATA_W    = 64;
    localparam int DEPTH     = 8;
    localparam int DIAG_W    = 4;
    localparam int MY_DIAG   = 3;
    localparam int AF_MARGIN = 2;

    logic              clk;
    logic              rst;
    logic              start;
    logic [4:0]        rows_expected;
    logic              pkt_valid;
    logic [DIAG_W-1:0] pkt_dest;
    logic              pkt_last;
    logic [DATA_W-1:0] pkt_data;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              rd_ready;
    logic              pe_full;
    logic              row_done;
    logic [4:0]        complete_count;
    logic              calc_complete;
    logic              overflow;

    int checks = 0;
    int errors = 0;
    logic [DATA_W:0] exp_q[$];

    diag_bus_receiver #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .DIAG_W    (DIAG_W),
        .MY_DIAG   (MY_DIAG),
        .AF_MARGIN (AF_MARGIN)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .rows_expected  (rows_expected),
        .pkt_valid      (pkt_valid),
        .pkt_dest       (pkt_dest),
        .pkt_last       (pkt_last),
        .pkt_data       (pkt_data),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .rd_last        (rd_last),
        .rd_ready       (rd_ready),
        .pe_full        (pe_full),
        .row_done       (row_done),
        .complete_count (complete_count),
        .calc_complete  (calc_complete),
        .overflow       (overflow)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [DATA_W:0] act, input logic [DATA_W:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic valid, input logic [DIAG_W-1:0] dest, input logic last,
                            input logic [DATA_W-1:0] data, input bit accepted);
        pkt_valid = valid;
        pkt_dest  = dest;
        pkt_last  = last;
        pkt_data  = data;
        if (accepted) exp_q.push_back({last, data});
        step();
        pkt_valid = 1'b0;
    endtask

    task automatic do_start(input logic [4:0] rows);
        start         = 1'b1;
        rows_expected = rows;
        step();
        start = 1'b0;
        exp_q.delete();
    endtask

    // Scoreboard monitor: compares every popped head against the expected queue.
    always @(negedge clk) begin
        if (!rst && rd_valid && rd_ready && !start) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got %0h required no entry", {rd_last, rd_data});
            end else begin
                check("pop_data", {rd_last, rd_data}, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        rows_expected = '0;
        pkt_valid     = 1'b0;
        pkt_dest      = '0;
        pkt_last      = 1'b0;
        pkt_data      = '0;
        rd_ready      = 1'b0;

        // Reset values
        #1;
        check("rst_rd_valid", 65'(rd_valid), 65'(0));
        check("rst_rd_data", 65'(rd_data), 65'(0));
        check("rst_pe_full", 65'(pe_full), 65'(0));
        check("rst_row_done", 65'(row_done), 65'(0));
        check("rst_count", 65'(complete_count), 65'(0));
        check("rst_calc", 65'(calc_complete), 65'(0));
        check("rst_overflow", 65'(overflow), 65'(0));
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        step();

        // Packets in IDLE are ignored
        send_pkt(1'b1, 4'd3, 1'b0, 64'h11, 1'b0);
        send_pkt(1'b1, 4'd3, 1'b1, 64'h12, 1'b0);
        check("idle_no_push", 65'(rd_valid), 65'(0));

        // Two rows streamed with continuous popping
        rd_ready = 1'b1;
        do_start(5'd2);
        check("start_calc", 65'(calc_complete), 65'(0));
        send_pkt(1'b1, 4'd3, 1'b0, 64'hA0, 1'b1);
        send_pkt(1'b1, 4'd3, 1'b1, 64'hA1, 1'b1);
        send_pkt(1'b1, 4'd3, 1'b0, 64'hA2, 1'b1);
        check("row1_done", 65'(row_done), 65'(1));
        check("row1_count", 65'(complete_count), 65'(1));
        send_pkt(1'b1, 4'd3, 1'b1, 64'hA3, 1'b1);
        check("row1_done_pulse", 65'(row_done), 65'(0));
        step();
        check("row2_done", 65'(row_done), 65'(1));
        check("row2_count", 65'(complete_count), 65'(2));
        check("row2_calc_early", 65'(calc_complete), 65'(0));
        step();
        check("row2_calc", 65'(calc_complete), 65'(1));
        check("row2_done_pulse", 65'(row_done), 65'(0));

        // Non-matching destination and invalid packets
        rd_ready = 1'b0;
        send_pkt(1'b1, 4'd5, 1'b0, 64'hB5, 1'b0);
        send_pkt(1'b1, 4'd5, 1'b1, 64'hB6, 1'b0);
        send_pkt(1'b0, 4'd3, 1'b0, 64'hB7, 1'b0);
        send_pkt(1'b0, 4'd3, 1'b1, 64'hB8, 1'b0);
        check("nomatch_rd_valid", 65'(rd_valid), 65'(0));
        check("nomatch_overflow", 65'(overflow), 65'(0));

        // Almost-full threshold, fill to full, overflow drop, pe_full release
        do_start(5'd10);
        for (int i = 0; i < 5; i++) send_pkt(1'b1, 4'd3, 1'b0, 64'hC0 + 64'(i), 1'b1);
        check("af_after5", 65'(pe_full), 65'(0));
        send_pkt(1'b1, 4'd3, 1'b0, 64'hC5, 1'b1);
        check("af_after6", 65'(pe_full), 65'(1));
        send_pkt(1'b1, 4'd3, 1'b0, 64'hC6, 1'b1);
        send_pkt(1'b1, 4'd3, 1'b0, 64'hC7, 1'b1);
        check("full_no_overflow", 65'(overflow), 65'(0));
        send_pkt(1'b1, 4'd3, 1'b0, 64'hC8, 1'b0);
        check("full_overflow", 65'(overflow), 65'(1));
        rd_ready = 1'b1;
        step();
        check("af_occ7", 65'(pe_full), 65'(1));
        step();
        check("af_occ6", 65'(pe_full), 65'(1));
        step();
        rd_ready = 1'b0;
        check("af_occ5", 65'(pe_full), 65'(0));

        // Half full, push and pop every cycle across pointer wrap
        do_start(5'd31);
        check("restart_overflow", 65'(overflow), 65'(0));
        for (int i = 0; i < 4; i++) send_pkt(1'b1, 4'd3, 1'b0, 64'hD0 + 64'(i), 1'b1);
        rd_ready = 1'b1;
        for (int i = 0; i < 20; i++)
            send_pkt(1'b1, 4'd3, (i % 5) == 4, 64'hE00 + 64'(i), 1'b1);
        check("stream_pe_full", 65'(pe_full), 65'(0));
        check("stream_overflow", 65'(overflow), 65'(0));
        check("stream_rd_valid", 65'(rd_valid), 65'(1));
        repeat (6) step();
        check("stream_drained", 65'(rd_valid), 65'(0));
        check("stream_queue_empty", 65'(exp_q.size()), 65'(0));
        check("stream_count", 65'(complete_count), 65'(4));

        // Overflow with entries held, then start mid-RECV clears everything
        rd_ready = 1'b0;
        for (int i = 0; i < 9; i++) send_pkt(1'b1, 4'd3, 1'b0, 64'hF0 + 64'(i), i < 8);
        check("mid_overflow", 65'(overflow), 65'(1));
        rd_ready = 1'b1;
        repeat (5) step();
        rd_ready = 1'b0;
        check("mid_held", 65'(rd_valid), 65'(1));
        do_start(5'd5);
        check("clr_rd_valid", 65'(rd_valid), 65'(0));
        check("clr_rd_data", 65'(rd_data), 65'(0));
        check("clr_count", 65'(complete_count), 65'(0));
        check("clr_overflow", 65'(overflow), 65'(0));
        check("clr_pe_full", 65'(pe_full), 65'(0));

        // rows_expected of zero reaches DONE one cycle after start
        do_start(5'd0);
        check("zero_rows_early", 65'(calc_complete), 65'(0));
        step();
        check("zero_rows_done", 65'(calc_complete), 65'(1));

        // Asynchronous reset mid-transfer
        send_pkt(1'b1, 4'd3, 1'b1, 64'h100, 1'b1);
        send_pkt(1'b1, 4'd3, 1'b0, 64'h101, 1'b1);
        send_pkt(1'b1, 4'd3, 1'b0, 64'h102, 1'b1);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        check("pre_rst_row_done", 65'(row_done), 65'(1));
        check("pre_rst_count", 65'(complete_count), 65'(1));
        #2 rst = 1'b1;
        #1;
        exp_q.delete();
        check("arst_rd_valid", 65'(rd_valid), 65'(0));
        check("arst_rd_data", 65'(rd_data), 65'(0));
        check("arst_rd_last", 65'(rd_last), 65'(0));
        check("arst_row_done", 65'(row_done), 65'(0));
        check("arst_count", 65'(complete_count), 65'(0));
        check("arst_calc", 65'(calc_complete), 65'(0));
        #20 rst = 1'b0;
        step();
        send_pkt(1'b1, 4'd3, 1'b0, 64'h200, 1'b0);
        step();
        check("post_rst_idle", 65'(rd_valid), 65'(0));
        check("post_rst_calc", 65'(calc_complete), 65'(0));

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
